// File: rtl/audio_fifo_loopback.sv
// audio_fifo_loopback: FT2232H 245 synchronous-FIFO loopback engine.
// Bytes read from the host are queued in a circular byte buffer and written
// back to the host in order. Owns the FT2232 reset, handshake and data bus.
module audio_fifo_loopback #(
    parameter int DEPTH        = 16,
    parameter int RESET_CYCLES = 16
) (
    input  logic        fifo_clk,
    input  logic        btn_reset,
    input  logic        fifo_rxf_n,
    input  logic        fifo_txe_n,
    output logic        ft2232_reset_n,
    output logic        fifo_oe_n,
    output logic        fifo_siwu,
    output logic        fifo_rd_n,
    output logic        fifo_wr_n,
    inout  wire  [7:0]  fifo_data,
    output logic [45:0] extension,
    output logic        led_reset,
    output logic        led_user
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_IDLE,
        ST_OE,
        ST_RD,
        ST_WR
    } state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      last_byte_q, last_byte_d;
    logic [7:0]      rx_cnt_q, rx_cnt_d;
    logic            led_user_q, led_user_d;
    logic            oe_n_q, oe_n_d;
    logic [7:0]      mem_q [DEPTH];

    logic            full;
    logic            empty;
    logic            capture;
    logic            send;
    logic [4:0]      count_ext;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Next-state, strobes and buffer bookkeeping.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        last_byte_d = last_byte_q;
        rx_cnt_d    = rx_cnt_q;
        led_user_d  = led_user_q;
        fifo_rd_n   = 1'b1;
        fifo_wr_n   = 1'b1;
        capture     = 1'b0;
        send        = 1'b0;

        case (state_q)
            ST_HOLD: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // Write-back wins so the buffer drains before refilling.
                if (!empty && !fifo_txe_n) begin
                    state_d = ST_WR;
                end else if (!full && !fifo_rxf_n) begin
                    state_d = ST_OE;
                end
            end
            ST_OE: begin
                state_d = ST_RD;
            end
            ST_RD: begin
                fifo_rd_n = full;
                capture   = !full && !fifo_rxf_n;
                if (fifo_rxf_n || full || (capture && count_q == CW'(DEPTH - 1))) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
                fifo_wr_n = empty || fifo_txe_n;
                send      = !fifo_wr_n;
                if (fifo_txe_n || empty || (send && count_q == CW'(1))) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_HOLD;
            end
        endcase

        // Capture and send never coincide: they live in different states.
        if (capture) begin
            wr_ptr_d    = wr_ptr_q + 1'b1;
            count_d     = count_q + 1'b1;
            last_byte_d = fifo_data;
            rx_cnt_d    = rx_cnt_q + 1'b1;
            if (rx_cnt_q == 8'hFF) begin
                led_user_d = !led_user_q;
            end
        end
        if (send) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            count_d  = count_q - 1'b1;
        end

        // Output enable is registered from the next state so it is glitch-free.
        oe_n_d = !(state_d == ST_OE || state_d == ST_RD);
    end

    // Control and status registers with asynchronous reset.
    always_ff @(posedge fifo_clk or posedge btn_reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (btn_reset) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_byte_q <= '0;
            rx_cnt_q    <= '0;
            led_user_q  <= 1'b0;
            oe_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            last_byte_q <= last_byte_d;
            rx_cnt_q    <= rx_cnt_d;
            led_user_q  <= led_user_d;
            oe_n_q      <= oe_n_d;
        end
    end

    // Byte buffer storage, written on each captured byte.
    always_ff @(posedge fifo_clk) begin
        // NOTE: the buffer array is deliberately not reset; count_q defines
        // which entries are valid, so stale contents are never observable.
        if (capture) begin
            mem_q[wr_ptr_q] <= fifo_data;
        end
    end

    // The block drives the bus only in WR, where fifo_oe_n is always high.
    assign fifo_data = (state_q == ST_WR) ? mem_q[rd_ptr_q] : 8'hzz;

    assign count_ext      = 5'(count_q);
    assign extension      = {33'b0, count_ext, last_byte_q};
    assign ft2232_reset_n = (state_q != ST_HOLD);
    assign led_reset      = (state_q == ST_HOLD);
    assign led_user       = led_user_q;
    assign fifo_oe_n      = oe_n_q;
    assign fifo_siwu      = 1'b1;

endmodule

// File: tb/tb_audio_fifo_loopback.sv
// Directed bench for audio_fifo_loopback: a host model feeds bytes when the
// block reads and checks every echoed byte against the order it delivered.
module tb_audio_fifo_loopback;

    logic        clk;
    logic        btn_reset;
    logic        rxf_n;
    logic        txe_n;
    logic        ft2232_reset_n;
    logic        fifo_oe_n;
    logic        fifo_siwu;
    logic        fifo_rd_n;
    logic        fifo_wr_n;
    wire  [7:0]  fifo_data;
    logic [45:0] extension;
    logic        led_reset;
    logic        led_user;

    logic [7:0]  host_byte;
    logic [7:0]  rx_q [$];
    logic [7:0]  exp_q [$];

    int n_cmp;
    int n_bad;
    int cyc;
    int rd_cnt;
    int wr_cnt;
    int first_rd_cyc;
    int first_wr_cyc;
    int last_rd_cyc;
    bit prev_oe_n;
    bit tx_block;
    bit throttle_en;

    audio_fifo_loopback #(.DEPTH(16), .RESET_CYCLES(16)) dut (
        .fifo_clk       (clk),
        .btn_reset      (btn_reset),
        .fifo_rxf_n     (rxf_n),
        .fifo_txe_n     (txe_n),
        .ft2232_reset_n (ft2232_reset_n),
        .fifo_oe_n      (fifo_oe_n),
        .fifo_siwu      (fifo_siwu),
        .fifo_rd_n      (fifo_rd_n),
        .fifo_wr_n      (fifo_wr_n),
        .fifo_data      (fifo_data),
        .extension      (extension),
        .led_reset      (led_reset),
        .led_user       (led_user)
    );

    // Host side of the bus: drives the head byte while the block enables it.
    assign fifo_data = (!fifo_oe_n) ? host_byte : 8'hzz;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    // One clock: update host inputs at negedge, then observe what the next
    // rising edge will transfer and check the bus protocol.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        host_byte = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        rxf_n     = (rx_q.size() == 0);
        txe_n     = throttle_en ? (((cyc / 3) % 2) == 1) : tx_block;
        #1;
        if (!fifo_oe_n) begin
            n_cmp++;
            if (fifo_data !== host_byte) begin
                n_bad++;
                $display("FAIL bus_contention cyc=%0d: got %h want %h", cyc, fifo_data, host_byte);
            end
        end
        if (!fifo_wr_n) begin
            n_cmp++;
            if (txe_n !== 1'b0) begin
                n_bad++;
                $display("FAIL wr_while_txe_high cyc=%0d: got txe_n=%b want 0", cyc, txe_n);
            end
            n_cmp++;
            if (fifo_oe_n !== 1'b1 || prev_oe_n !== 1'b1) begin
                n_bad++;
                $display("FAIL turnaround cyc=%0d: got oe_n=%b prev=%b want 1/1", cyc, fifo_oe_n, prev_oe_n);
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write cyc=%0d: got %h want no write", cyc, fifo_data);
            end else begin
                if (fifo_data !== exp_q[0]) begin
                    n_bad++;
                    $display("FAIL echo_data cyc=%0d: got %h want %h", cyc, fifo_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            wr_cnt++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
        end
        if (!fifo_rd_n && !rxf_n) begin
            exp_q.push_back(host_byte);
            void'(rx_q.pop_front());
            rd_cnt++;
            last_rd_cyc = cyc;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end
        prev_oe_n = fifo_oe_n;
    endtask

    task automatic test_reset();
        btn_reset = 1'b0;
        #2;
        btn_reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_cmp++;
            if (ft2232_reset_n !== 1'b0 || fifo_oe_n !== 1'b1 || fifo_rd_n !== 1'b1 ||
                fifo_wr_n !== 1'b1 || led_reset !== 1'b1 || led_user !== 1'b0 ||
                extension !== 46'h0 || fifo_siwu !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_values: got rst_n=%b oe=%b rd=%b wr=%b ledr=%b ledu=%b ext=%h siwu=%b want 0 1 1 1 1 0 0 1",
                         ft2232_reset_n, fifo_oe_n, fifo_rd_n, fifo_wr_n, led_reset, led_user, extension, fifo_siwu);
            end
        end
        btn_reset = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            cycle();
            n_cmp++;
            if (ft2232_reset_n !== (i == 16) || led_reset !== (i != 16)) begin
                n_bad++;
                $display("FAIL reset_release edge=%0d: got rst_n=%b led_reset=%b want %b %b",
                         i, ft2232_reset_n, led_reset, (i == 16), (i != 16));
            end
            n_cmp++;
            if (fifo_oe_n !== 1'b1 || fifo_wr_n !== 1'b1) begin
                n_bad++;
                $display("FAIL hold_bus edge=%0d: got oe=%b wr=%b want 1 1", i, fifo_oe_n, fifo_wr_n);
            end
        end
    endtask

    task automatic test_single_byte();
        int start, rd0, wr0;
        start = cyc; rd0 = rd_cnt; wr0 = wr_cnt;
        first_rd_cyc = -1; first_wr_cyc = -1;
        tx_block = 1'b0;
        rx_q.push_back(8'hA5);
        for (int i = 0; i < 10; i++) cycle();
        n_cmp++;
        if (rd_cnt - rd0 != 1 || wr_cnt - wr0 != 1) begin
            n_bad++;
            $display("FAIL single_counts: got reads=%0d writes=%0d want 1 1", rd_cnt - rd0, wr_cnt - wr0);
        end
        n_cmp++;
        if (first_rd_cyc != start + 3) begin
            n_bad++;
            $display("FAIL read_latency: got %0d want %0d", first_rd_cyc - start, 3);
        end
        n_cmp++;
        if (first_wr_cyc != start + 6) begin
            n_bad++;
            $display("FAIL write_latency: got %0d want %0d", first_wr_cyc - start, 6);
        end
        n_cmp++;
        if (extension !== 46'h00A5) begin
            n_bad++;
            $display("FAIL single_extension: got %h want %h", extension, 46'h00A5);
        end
    endtask

    task automatic test_burst_wrap();
        int start, rd0, wr0, guard;
        start = cyc; rd0 = rd_cnt; wr0 = wr_cnt;
        tx_block = 1'b1;
        for (int i = 0; i < 64; i++) rx_q.push_back(8'(i));
        for (int i = 0; i < 30; i++) cycle();
        n_cmp++;
        if (rd_cnt - rd0 != 16 || wr_cnt != wr0) begin
            n_bad++;
            $display("FAIL burst_fill: got reads=%0d writes=%0d want 16 0", rd_cnt - rd0, wr_cnt - wr0);
        end
        n_cmp++;
        if (last_rd_cyc != start + 18) begin
            n_bad++;
            $display("FAIL burst_full_stop: got last read at %0d want %0d", last_rd_cyc - start, 18);
        end
        n_cmp++;
        if (fifo_rd_n !== 1'b1 || extension !== 46'h100F) begin
            n_bad++;
            $display("FAIL burst_full_state: got rd_n=%b ext=%h want 1 %h", fifo_rd_n, extension, 46'h100F);
        end
        tx_block = 1'b0;
        guard = 0;
        while ((wr_cnt - wr0) < 64 && guard < 2000) begin
            cycle();
            guard++;
        end
        cycle();
        n_cmp++;
        if (wr_cnt - wr0 != 64 || exp_q.size() != 0 || rx_q.size() != 0) begin
            n_bad++;
            $display("FAIL burst_drain: got writes=%0d pending=%0d unsent=%0d want 64 0 0",
                     wr_cnt - wr0, exp_q.size(), rx_q.size());
        end
        n_cmp++;
        if (extension !== 46'h003F) begin
            n_bad++;
            $display("FAIL burst_extension: got %h want %h", extension, 46'h003F);
        end
    endtask

    task automatic test_throttle();
        int rd0, wr0, guard;
        rd0 = rd_cnt; wr0 = wr_cnt;
        n_cmp++;
        if (led_user !== 1'b0) begin
            n_bad++;
            $display("FAIL led_user_before: got %b want 0", led_user);
        end
        for (int i = 0; i < 200; i++) rx_q.push_back(8'((i * 7 + 3) % 256));
        throttle_en = 1'b1;
        guard = 0;
        while ((wr_cnt - wr0) < 200 && guard < 5000) begin
            cycle();
            guard++;
        end
        throttle_en = 1'b0;
        tx_block    = 1'b0;
        cycle();
        n_cmp++;
        if (rd_cnt - rd0 != 200 || wr_cnt - wr0 != 200 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL throttle_counts: got reads=%0d writes=%0d pending=%0d want 200 200 0",
                     rd_cnt - rd0, wr_cnt - wr0, exp_q.size());
        end
        n_cmp++;
        if (led_user !== 1'b1) begin
            n_bad++;
            $display("FAIL led_user_wrap: got %b want 1", led_user);
        end
    endtask

    task automatic test_reset_mid_burst();
        int rd0, wr0, guard;
        rd0 = rd_cnt;
        tx_block = 1'b1;
        for (int i = 0; i < 20; i++) rx_q.push_back(8'hC0 + 8'(i));
        guard = 0;
        while ((rd_cnt - rd0) < 5 && guard < 50) begin
            cycle();
            guard++;
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (fifo_oe_n !== 1'b0 || extension !== 46'h05C4) begin
            n_bad++;
            $display("FAIL mid_burst_state: got oe=%b ext=%h want 0 %h", fifo_oe_n, extension, 46'h05C4);
        end
        btn_reset = 1'b1;
        #1;
        n_cmp++;
        if (ft2232_reset_n !== 1'b0 || fifo_oe_n !== 1'b1 || fifo_rd_n !== 1'b1 ||
            fifo_wr_n !== 1'b1 || led_reset !== 1'b1 || led_user !== 1'b0 || extension !== 46'h0) begin
            n_bad++;
            $display("FAIL async_reset: got rst_n=%b oe=%b rd=%b wr=%b ledr=%b ledu=%b ext=%h want 0 1 1 1 1 0 0",
                     ft2232_reset_n, fifo_oe_n, fifo_rd_n, fifo_wr_n, led_reset, led_user, extension);
        end
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++) cycle();
        btn_reset = 1'b0;
        tx_block  = 1'b0;
        wr0 = wr_cnt;
        for (int i = 0; i < 40; i++) cycle();
        n_cmp++;
        if (wr_cnt != wr0 || extension !== 46'h0) begin
            n_bad++;
            $display("FAIL stale_echo: got writes=%0d ext=%h want 0 0", wr_cnt - wr0, extension);
        end
        rx_q.push_back(8'h3C);
        guard = 0;
        while ((wr_cnt - wr0) < 1 && guard < 20) begin
            cycle();
            guard++;
        end
        cycle();
        n_cmp++;
        if (wr_cnt - wr0 != 1 || exp_q.size() != 0 || extension !== 46'h003C) begin
            n_bad++;
            $display("FAIL post_reset_echo: got writes=%0d pending=%0d ext=%h want 1 0 %h",
                     wr_cnt - wr0, exp_q.size(), extension, 46'h003C);
        end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0;
        rd_cnt = 0; wr_cnt = 0;
        first_rd_cyc = -1; first_wr_cyc = -1; last_rd_cyc = -1;
        prev_oe_n = 1'b1; tx_block = 1'b1; throttle_en = 1'b0;
        rxf_n = 1'b1; txe_n = 1'b1; host_byte = 8'h00;
        test_reset();
        test_single_byte();
        test_burst_wrap();
        test_throttle();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
